// File: rtl/mdf_mul_pipe.sv
// Pipelined WIDTH x WIDTH multiplier: one partial-product stage, log2(WIDTH) pairwise
// adder levels, then an output register; MUL/MULH/MULHU/MULHSU with tag passthrough.
module mdf_mul_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAGW  = 4
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataIn1,
    input  logic [WIDTH-1:0] dataIn2,
    input  logic [TAGW-1:0]  in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAGW-1:0]  out_tag,
    output logic             busy
);

    localparam int unsigned LOGW = $clog2(WIDTH);
    localparam int unsigned LAT  = LOGW + 1;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned NPP  = 2 * WIDTH - 1;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHU  = 2'b10,
        OP_MULHSU = 2'b11
    } op_e;

    op_e                         op_in;
    logic                        a_signed;
    logic                        b_signed;
    logic [PW-1:0]               a_ext;
    logic [PW-1:0]               prod;
    logic                        advance;

    // All adder-tree levels share one array: level s starts at PW - 2*(WIDTH>>s).
    logic [PW-1:0]               pp_d [NPP];
    logic [PW-1:0]               pp_q [NPP];

    logic [LAT-1:0]              vld_q, vld_d;
    logic [LAT-1:0][1:0]         op_q;
    logic [LAT-1:0][TAGW-1:0]    tag_q;
    logic                        out_valid_q, out_valid_d;
    logic [WIDTH-1:0]            result_q, result_d;
    logic [TAGW-1:0]             out_tag_q, out_tag_d;

    assign op_in    = op_e'(op);
    assign advance  = !(out_valid_q && !out_ready);
    assign in_ready = advance;

    always_comb begin
        a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU);
        b_signed = (op_in == OP_MULH);
        a_ext    = a_signed ? {{WIDTH{dataIn1[WIDTH-1]}}, dataIn1}
                            : {{WIDTH{1'b0}}, dataIn1};
    end

    // A signed multiplier's top bit weighs -2^(WIDTH-1), so that row is negated.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign pp_d[i] = !dataIn2[i] ? '0 :
                         ((b_signed && (i == WIDTH - 1)) ? -(a_ext << i) : (a_ext << i));
    end

    for (genvar s = 1; s <= LOGW; s++) begin : g_lvl
        localparam int unsigned SRC = PW - 2 * (WIDTH >> (s - 1));
        localparam int unsigned DST = PW - 2 * (WIDTH >> s);
        for (genvar j = 0; j < (WIDTH >> s); j++) begin : g_add
            assign pp_d[DST + j] = pp_q[SRC + 2 * j] + pp_q[SRC + 2 * j + 1];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            pp_q  <= pp_d;
            op_q  <= {op_q[LAT-2:0], op};
            tag_q <= {tag_q[LAT-2:0], in_tag};
        end
    end

    always_comb begin
        vld_d       = vld_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        out_tag_d   = out_tag_q;
        prod        = pp_q[NPP-1];
        if (flush) begin
            vld_d       = '0;
            out_valid_d = 1'b0;
        end else if (advance) begin
            vld_d       = {vld_q[LAT-2:0], in_valid};
            out_valid_d = vld_q[LAT-1];
            if (vld_q[LAT-1]) begin
                result_d  = (op_q[LAT-1] == OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
                out_tag_d = tag_q[LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;
    assign busy      = (|vld_q) || out_valid_q;

endmodule

// File: tb/tb_mdf_mul_pipe.sv
// Bench for mdf_mul_pipe: directed scenarios plus random traffic, checked each cycle
// against a queue model of in-flight operations aged by non-stalled edges.
module tb_mdf_mul_pipe;

    localparam int W   = 32;
    localparam int TW  = 4;
    localparam int LAT = 6;

    logic          clk = 1'b0;
    logic          nRST, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [1:0]    op;
    logic [W-1:0]  dataIn1, dataIn2, result;
    logic [TW-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    mdf_mul_pipe #(.WIDTH(W), .TAGW(TW)) dut (
        .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .dataIn1(dataIn1), .dataIn2(dataIn2), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .busy(busy)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        int            age;
    } ent_t;

    ent_t          mq[$];
    logic [TW-1:0] vlog[$];
    int            vcyc[$];
    int            cyc   = 0;
    int            total = 0;
    int            bad   = 0;

    function automatic logic [W-1:0] ref_mul(logic [1:0] m, logic [W-1:0] a, logic [W-1:0] b);
        longint       sa, sb, ua, ub;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (m)
            2'd1:    p = sa * sb;
            2'd3:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (m == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit model_valid();
        return (mq.size() > 0) && (mq[0].age == LAT);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step(input bit iv, input logic [1:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t,
                        input bit ordy, input bit fl, input bit rn);
        bit   mv;
        ent_t e;
        in_valid = iv; op = m; dataIn1 = a; dataIn2 = b; in_tag = t;
        out_ready = ordy; flush = fl; nRST = rn;
        mv = model_valid();
        #1;
        chk("in_ready", in_ready, !(mv && !ordy));
        if (out_valid && ordy) begin
            vlog.push_back(out_tag);
            vcyc.push_back(cyc);
        end
        @(posedge clk);
        if (!rn || fl) begin
            mq.delete();
        end else if (!(mv && !ordy)) begin
            if (mv) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age++;
            if (iv) begin
                e.res = ref_mul(m, a, b); e.tag = t; e.age = 0;
                mq.push_back(e);
            end
        end
        @(negedge clk);
        mv = model_valid();
        chk("out_valid", out_valid, mv);
        chk("busy", busy, mq.size() != 0);
        if (mv) begin
            chk("result", result, mq[0].res);
            chk("out_tag", out_tag, mq[0].tag);
        end
        cyc++;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 2'd0, '0, '0, '0, ordy, 1'b0, 1'b1);
    endtask

    task automatic wait_valid(output logic [W-1:0] r, output logic [TW-1:0] t, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            idle(1'b1);
            n++;
        end
        chk("wait_valid", out_valid, 1'b1);
        r = result;
        t = out_tag;
    endtask

    initial begin
        logic [W-1:0]  r;
        logic [TW-1:0] t;
        int            n;
        logic [1:0]    swp_op [5];
        logic [W-1:0]  swp_a  [5];
        logic [W-1:0]  swp_b  [5];
        logic [W-1:0]  swp_e  [5];

        nRST = 1'b0; in_valid = 1'b0; op = '0; dataIn1 = '0; dataIn2 = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // reset
        step(1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_result", result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);

        // single op 3 x 5, tag 2
        step(1'b1, 2'd0, 32'd3, 32'd5, 4'd2, 1'b1, 1'b0, 1'b1);
        wait_valid(r, t, n);
        chk("single_lat", n, LAT);
        chk("single_res", r, 15);
        chk("single_tag", t, 2);
        idle(1'b1);
        chk("single_busy", busy, 0);

        // mode sweep
        swp_op[0] = 2'd0; swp_a[0] = 32'hFFFF_FFFF; swp_b[0] = 32'hFFFF_FFFF; swp_e[0] = 32'h0000_0001;
        swp_op[1] = 2'd1; swp_a[1] = 32'hFFFF_FFFF; swp_b[1] = 32'hFFFF_FFFF; swp_e[1] = 32'h0000_0000;
        swp_op[2] = 2'd2; swp_a[2] = 32'hFFFF_FFFF; swp_b[2] = 32'hFFFF_FFFF; swp_e[2] = 32'hFFFF_FFFE;
        swp_op[3] = 2'd3; swp_a[3] = 32'hFFFF_FFFF; swp_b[3] = 32'hFFFF_FFFF; swp_e[3] = 32'hFFFF_FFFF;
        swp_op[4] = 2'd1; swp_a[4] = 32'h8000_0000; swp_b[4] = 32'h8000_0000; swp_e[4] = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, swp_op[i], swp_a[i], swp_b[i], TW'(i), 1'b1, 1'b0, 1'b1);
            wait_valid(r, t, n);
            chk("sweep_res", r, swp_e[i]);
            idle(1'b1);
        end

        // streaming: 8 back-to-back ops
        vlog.delete(); vcyc.delete();
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'($urandom_range(0, 3)), pick(), pick(), TW'(i), 1'b1, 1'b0, 1'b1);
        repeat (12) idle(1'b1);
        chk("stream_count", vlog.size(), 8);
        for (int i = 0; i < 8; i++) chk("stream_tag", vlog[i], i);
        chk("stream_span", vcyc[7] - vcyc[0], 7);

        // backpressure with a full pipeline
        vlog.delete(); vcyc.delete();
        for (int i = 0; i < 7; i++)
            step(1'b1, 2'($urandom_range(0, 3)), pick(), pick(), TW'(i), 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 2'd0, 32'd1, 32'd1, 4'd9, 1'b0, 1'b0, 1'b1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_tag", out_tag, 0);
        repeat (12) idle(1'b1);
        chk("bp_count", vlog.size(), 7);
        for (int i = 0; i < 7; i++) chk("bp_order", vlog[i], i);
        chk("bp_busy", busy, 0);

        // flush with 3 ops in flight, then 7 x 9 tag 5
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'd0, pick(), pick(), TW'(i + 10), 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd0, 32'd1, 32'd1, 4'd3, 1'b1, 1'b1, 1'b1);
        chk("flush_busy", busy, 0);
        step(1'b1, 2'd0, 32'd7, 32'd9, 4'd5, 1'b1, 1'b0, 1'b1);
        wait_valid(r, t, n);
        chk("flush_lat", n, LAT);
        chk("flush_res", r, 63);
        chk("flush_tag", t, 5);
        idle(1'b1);

        // reset with 4 ops in flight
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'($urandom_range(0, 3)), pick(), pick(), TW'(i), 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd0, 32'd2, 32'd2, 4'd1, 1'b1, 1'b0, 1'b0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        repeat (12) idle(1'b1);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick(), pick(),
                 TW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 149) != 0));
        repeat (12) idle(1'b1);
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
